// File: rtl/ofs_rst_seq_pkg.sv
// Shared types and defaults for the FIM reset sequencer.
// State encodings are visible on the seq_state debug port.
package ofs_rst_seq_pkg;

  localparam int SEQ_STATE_W = 3;

  localparam int DEF_NUM_DOMAINS        = 4;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_STAGE_GAP_CYCLES   = 64;
  localparam int DEF_ACK_TIMEOUT_CYCLES = 4096;

  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_WAIT_ACK  = 3'd4,
    ST_GAP       = 3'd5,
    ST_RUN       = 3'd6
  } t_rst_seq_state;

  // Width of a saturating counter that must be able to hold lim.
  function automatic int cnt_w(input int lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/ofs_rst_seq_sync.sv
// Parameterized-width two-flop synchronizer with a
// configurable reset value.
module ofs_rst_seq_sync #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ofs_rst_sequencer.sv
// Power-on / fault reset sequencer for the FIM domains.
// Define RST_SEQ_ACK_TIMEOUT_EN to bound the acknowledge wait.
module ofs_rst_sequencer
  import ofs_rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS        = DEF_NUM_DOMAINS,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int STAGE_GAP_CYCLES   = DEF_STAGE_GAP_CYCLES,
  parameter int ACK_TIMEOUT_CYCLES = DEF_ACK_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   pcie_perst_n,
  input  logic [NUM_DOMAINS-1:0] dom_ack,
  output logic [NUM_DOMAINS-1:0] dom_rst,
  output logic                   all_ready,
  output logic [SEQ_STATE_W-1:0] seq_state,
  output logic                   timeout_err,
  output logic [NUM_DOMAINS-1:0] timeout_dom
);

  localparam int IDX_W =
    (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int STB_W = cnt_w(LOCK_STABLE_CYCLES);
  localparam int GAP_W = cnt_w(STAGE_GAP_CYCLES);

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_DOMAINS - 1);
  localparam logic [STB_W-1:0] STB_LIM =
    STB_W'(LOCK_STABLE_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LIM =
    GAP_W'(STAGE_GAP_CYCLES - 1);

  logic                   lock_s;
  logic                   perst_s;
  logic [NUM_DOMAINS-1:0] ack_s;

  ofs_rst_seq_sync #(.WIDTH(1), .RST_VAL(1'b0)) u_sync_lock (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  ofs_rst_seq_sync #(.WIDTH(1), .RST_VAL(1'b0)) u_sync_perst (
    .clk (clk),
    .rst (rst),
    .d   (pcie_perst_n),
    .q   (perst_s)
  );

  ofs_rst_seq_sync #(
    .WIDTH   (NUM_DOMAINS),
    .RST_VAL ('0)
  ) u_sync_ack (
    .clk (clk),
    .rst (rst),
    .d   (dom_ack),
    .q   (ack_s)
  );

  t_rst_seq_state         state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [STB_W-1:0]       stb_q, stb_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
  logic                   rdy_q, rdy_d;

  logic good;
  logic in_seq;
  logic ack_cur;
  logic ack_go;

`ifdef RST_SEQ_ACK_TIMEOUT_EN
  localparam int ATO_W = cnt_w(ACK_TIMEOUT_CYCLES);
  localparam logic [ATO_W-1:0] ATO_LIM =
    ATO_W'(ACK_TIMEOUT_CYCLES - 1);

  logic [ATO_W-1:0]       ato_q, ato_d;
  logic                   terr_q, terr_d;
  logic [NUM_DOMAINS-1:0] tdom_q, tdom_d;
  logic                   ato_hit;
`endif

  assign good    = lock_s & perst_s;
  assign in_seq  = (state_q != ST_IDLE) &&
                   (state_q != ST_WAIT_LOCK);
  assign ack_cur = ack_s[idx_q];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    stb_d     = stb_q;
    gap_d     = gap_q;
    dom_rst_d = dom_rst_q;
    rdy_d     = rdy_q;
    ack_go    = 1'b0;
`ifdef RST_SEQ_ACK_TIMEOUT_EN
    ato_d     = ato_q;
    terr_d    = terr_q;
    tdom_d    = tdom_q;
    ato_hit   = 1'b0;
`endif

    // Loss of good beats any ack or counter expiry this cycle.
    if (in_seq && !good) begin
      state_d   = ST_WAIT_LOCK;
      idx_d     = '0;
      stb_d     = '0;
      gap_d     = '0;
      dom_rst_d = '1;
      rdy_d     = 1'b0;
`ifdef RST_SEQ_ACK_TIMEOUT_EN
      ato_d     = '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (good) begin
            stb_d   = '0;
            state_d = ST_STABLE;
          end
        end
        ST_STABLE: begin
          if (stb_q == STB_LIM) begin
            idx_d   = '0;
            state_d = ST_RELEASE;
          end else begin
            stb_d = stb_q + STB_W'(1);
          end
        end
        ST_RELEASE: begin
          dom_rst_d[idx_q] = 1'b0;
          state_d          = ST_WAIT_ACK;
`ifdef RST_SEQ_ACK_TIMEOUT_EN
          ato_d            = '0;
`endif
        end
        ST_WAIT_ACK: begin
`ifdef RST_SEQ_ACK_TIMEOUT_EN
          ato_hit = !ack_cur && (ato_q == ATO_LIM);
          if (!ack_cur && !ato_hit) begin
            ato_d = ato_q + ATO_W'(1);
          end
          if (ato_hit) begin
            terr_d        = 1'b1;
            tdom_d[idx_q] = 1'b1;
          end
          ack_go = ack_cur | ato_hit;
`else
          ack_go = ack_cur;
`endif
          if (ack_go) begin
            if (idx_q == LAST_IDX) begin
              rdy_d   = 1'b1;
              state_d = ST_RUN;
            end else begin
              gap_d   = '0;
              state_d = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LIM) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_RELEASE;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        ST_RUN: begin
          rdy_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      stb_q     <= '0;
      gap_q     <= '0;
      dom_rst_q <= '1;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      stb_q     <= stb_d;
      gap_q     <= gap_d;
      dom_rst_q <= dom_rst_d;
      rdy_q     <= rdy_d;
    end
  end

`ifdef RST_SEQ_ACK_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ato_q  <= '0;
      terr_q <= 1'b0;
      tdom_q <= '0;
    end else begin
      ato_q  <= ato_d;
      terr_q <= terr_d;
      tdom_q <= tdom_d;
    end
  end

  assign timeout_err = terr_q;
  assign timeout_dom = tdom_q;
`else
  assign timeout_err = 1'b0;
  assign timeout_dom = '0;
`endif

  assign dom_rst   = dom_rst_q;
  assign all_ready = rdy_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_ofs_rst_sequencer.sv
// Bench for ofs_rst_sequencer: deadline-based reference model,
// per-cycle compare, directed latency checks, random faults.
module tb_ofs_rst_sequencer;

  localparam int N = 3;
  localparam int L = 8;
  localparam int G = 4;
  localparam int T = 16;
`ifdef RST_SEQ_ACK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         pll_locked;
  logic         pcie_perst_n;
  logic [N-1:0] dom_ack;
  logic [N-1:0] dom_rst;
  logic         all_ready;
  logic [2:0]   seq_state;
  logic         timeout_err;
  logic [N-1:0] timeout_dom;

  logic         auto_ack;
  logic [N-1:0] auto_val;
  logic [N-1:0] man_ack;
  logic [N-1:0] never;
  bit           drop_en;
  int           dly [N];
  int           acnt[N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign dom_ack = auto_ack ? auto_val : man_ack;

  ofs_rst_sequencer #(
    .NUM_DOMAINS        (N),
    .LOCK_STABLE_CYCLES (L),
    .STAGE_GAP_CYCLES   (G),
    .ACK_TIMEOUT_CYCLES (T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .pcie_perst_n (pcie_perst_n),
    .dom_ack      (dom_ack),
    .dom_rst      (dom_rst),
    .all_ready    (all_ready),
    .seq_state    (seq_state),
    .timeout_err  (timeout_err),
    .timeout_dom  (timeout_dom)
  );

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  // Reference model: absolute-edge deadlines, not counters.
  typedef enum int {P_BOOT, P_HOLD, P_TIMED, P_ACK, P_DONE} phase_t;
  phase_t       m_ph;
  int           m_ed, m_due, m_t0, m_nxt;
  bit           m_g1, m_g2, m_good, m_hit, m_to;
  logic [N-1:0] m_a1, m_a2, m_acks;
  logic [N-1:0] m_rst, m_tdom;
  bit           m_rdy, m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = P_BOOT; m_ed = 0; m_due = 0; m_t0 = 0; m_nxt = 0;
      m_g1 = 0; m_g2 = 0; m_a1 = '0; m_a2 = '0;
      m_rst = '1; m_rdy = 0; m_err = 0; m_tdom = '0;
    end else begin
      m_good = m_g2;
      m_acks = m_a2;
      m_g2 = m_g1;
      m_g1 = pll_locked & pcie_perst_n;
      m_a2 = m_a1;
      m_a1 = dom_ack;
      m_ed++;
      if (m_ph == P_BOOT) begin
        m_ph = P_HOLD;
      end else if (m_ph == P_HOLD) begin
        if (m_good) begin
          m_ph = P_TIMED; m_due = m_ed + L + 2; m_nxt = 0;
        end
      end else if (!m_good) begin
        m_rst = '1; m_rdy = 0; m_ph = P_HOLD;
      end else if (m_ph == P_TIMED) begin
        if (m_ed == m_due) begin
          m_rst[m_nxt] = 1'b0; m_ph = P_ACK; m_t0 = m_ed;
        end
      end else if (m_ph == P_ACK) begin
        m_hit = m_acks[m_nxt];
        m_to  = TO_EN && !m_hit && (m_ed == m_t0 + T);
        if (m_to) begin
          m_err = 1; m_tdom[m_nxt] = 1'b1;
        end
        if (m_hit || m_to) begin
          if (m_nxt == N - 1) begin
            m_rdy = 1; m_ph = P_DONE;
          end else begin
            m_nxt++; m_due = m_ed + G + 1; m_ph = P_TIMED;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("dom_rst", dom_rst, m_rst);
    chk("all_ready", all_ready, m_rdy);
    chk("timeout_err", timeout_err, m_err);
    chk("timeout_dom", timeout_dom, m_tdom);
  end

  // Acknowledge responder driven by the DUT's released domains.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (dom_rst[i] !== 1'b0) begin
        acnt[i] = 0; auto_val[i] = 1'b0;
      end else if (!never[i]) begin
        if (drop_en && $urandom_range(0, 31) == 0) begin
          acnt[i] = 0; auto_val[i] = 1'b0;
        end else begin
          if (acnt[i] < dly[i]) acnt[i]++;
          auto_val[i] = (acnt[i] >= dly[i]);
        end
      end
    end
  end

  task automatic wait_out(input logic [3:0] want,
                          input int lim, output int n);
    n = 0;
    while ({all_ready, dom_rst} !== want && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lock_low, perst_low;
    rst = 1'b1; pll_locked = 1'b1; pcie_perst_n = 1'b1;
    auto_ack = 1'b0; man_ack = '0; never = '0; drop_en = 0;
    for (int i = 0; i < N; i++) dly[i] = 5;
    repeat (3) @(negedge clk);
    chk("reset_state", seq_state, 0);
    chk("reset_dom_rst", dom_rst, 3'b111);
    rst = 1'b0;

    wait_out(4'b0110, 60, n);
    chk("dom0_release_lat", n, 13);
    @(negedge clk); man_ack = 3'b001;
    wait_out(4'b0100, 60, n);
    chk("dom1_release_lat", n, 8);
    @(negedge clk); man_ack = 3'b011;
    wait_out(4'b0000, 60, n);
    chk("dom2_release_lat", n, 8);
    @(negedge clk); man_ack = 3'b111;
    wait_out(4'b1000, 60, n);
    chk("all_ready_lat", n, 3);
    chk("run_state", seq_state, 6);

    @(negedge clk); pcie_perst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("fault_not_early", dom_rst, 3'b000);
    @(posedge clk); #1;
    chk("fault_dom_rst", dom_rst, 3'b111);
    chk("fault_ready", all_ready, 0);
    chk("fault_state", seq_state, 1);

    @(negedge clk);
    man_ack = '0; auto_ack = 1'b1; pcie_perst_n = 1'b1;
    wait_out(4'b1000, 400, n);
    chk("reseq_ready", all_ready, 1);

    @(negedge clk); pcie_perst_n = 1'b0;
    repeat (4) @(negedge clk);
    pcie_perst_n = 1'b1;
    wait_out(4'b0110, 60, n);
    chk("mid_dom0_released", dom_rst, 3'b110);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dom_rst", dom_rst, 3'b111);
    chk("async_rst_ready", all_ready, 0);
    chk("async_rst_state", seq_state, 0);
    chk("async_rst_terr", timeout_err, 0);
    chk("async_rst_tdom", timeout_dom, 0);

    auto_ack = 1'b0; man_ack = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); pll_locked = 1'b0;
    @(negedge clk); pll_locked = 1'b1;
    wait_out(4'b0110, 60, n);
    chk("glitch_release_lat", n, 13);

    @(negedge clk); man_ack = 3'b001;
    wait_out(4'b0100, 60, n);
    chk("dom1_release_lat2", n, 8);
    repeat (3) @(negedge clk);
    pll_locked = 1'b0; man_ack = 3'b011;
    repeat (3) @(posedge clk); #1;
    chk("coinc_dom_rst", dom_rst, 3'b111);
    chk("coinc_state", seq_state, 1);

    @(negedge clk); pll_locked = 1'b1; man_ack = '0;
    wait_out(4'b0110, 60, n);
    chk("dom0_release_lat3", n, 13);
    @(negedge clk); man_ack = 3'b001;
    wait_out(4'b0100, 60, n);
`ifdef RST_SEQ_ACK_TIMEOUT_EN
    n = 0;
    while (timeout_err !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_lat", n, 16);
    chk("timeout_dom_val", timeout_dom, 3'b010);
    wait_out(4'b0000, 60, n);
    chk("post_timeout_release", n, 5);
    @(negedge clk); man_ack = 3'b101;
    wait_out(4'b1000, 60, n);
    chk("timeout_ready_lat", n, 3);
    chk("timeout_err_sticky", timeout_err, 1);
`else
    repeat (40) @(posedge clk); #1;
    chk("no_timeout_err", timeout_err, 0);
    chk("stuck_wait_ack", seq_state, 4);
    chk("stuck_dom_rst", dom_rst, 3'b100);
`endif

    @(posedge clk); #2 rst = 1'b1;
    auto_ack = 1'b1; drop_en = 1;
    pll_locked = 1'b1; pcie_perst_n = 1'b1;
    lock_low = 0; perst_low = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 400 == 0) begin
        for (int i = 0; i < N; i++) begin
          dly[i] = $urandom_range(1, 8);
          never[i] = TO_EN && ($urandom_range(0, 5) == 0);
        end
      end
      if (lock_low > 0) lock_low--;
      else if ($urandom_range(0, 299) == 0)
        lock_low = $urandom_range(1, 6);
      if (perst_low > 0) perst_low--;
      else if ($urandom_range(0, 399) == 0)
        perst_low = $urandom_range(1, 6);
      pll_locked   = (lock_low == 0);
      pcie_perst_n = (perst_low == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
